vth_read_detector: RTL and testbench

Read-side detector for the NVM channel model, sitting downstream of the RTN distortion stage. It accepts a packed word of two distorted threshold voltages, senses each against three read reference voltages with one comparison per cycle, and maps each cell to a 2-bit MLC level. It Gray-decodes both cells and compares them with the written symbol. It also keeps saturating symbol-error and bit-error counters for raw BER measurement.

---
 rtl/vth_read_detector_if.sv | 23 ++
 rtl/vth_read_detector.sv | 152 +++++++++++++++
 tb/tb_vth_read_detector.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/vth_read_detector_if.sv
// Word-in / detection-out handshake bundle for the read-side Vth detector.
interface vth_read_detector_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_expected;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_level_a;
  logic [1:0]  out_level_b;
  logic [3:0]  out_bits;
  logic [2:0]  out_err_bits;

  modport master (
    output in_valid, in_data, in_expected, out_ready,
    input  in_ready, out_valid, out_level_a, out_level_b, out_bits, out_err_bits
  );

  modport slave (
    input  in_valid, in_data, in_expected, out_ready,
    output in_ready, out_valid, out_level_a, out_level_b, out_bits, out_err_bits
  );
endinterface

// File: rtl/vth_read_detector.sv
// Senses two cell Vths against three read references (one compare per cycle),
// Gray-decodes them and accumulates saturating symbol/bit error counts.
module vth_read_detector #(
  parameter logic [15:0] VREF0 = 16'h0400,
  parameter logic [15:0] VREF1 = 16'h0800,
  parameter logic [15:0] VREF2 = 16'h0C00
) (
  input  logic                clk,
  input  logic                reset,
  vth_read_detector_if.slave  bus,
  input  logic                clr_cnt,
  output logic [31:0]         sym_err_cnt,
  output logic [31:0]         bit_err_cnt
);

  typedef enum logic [1:0] {IDLE, SENSE_A, SENSE_B, DONE} state_t;

  state_t      state_q;
  logic [1:0]  idx_q;
  logic [15:0] vth_a_q, vth_b_q;
  logic [3:0]  exp_q;
  logic [1:0]  lvl_a_q;
  logic        out_valid_q;
  logic [1:0]  out_lvl_a_q, out_lvl_b_q;
  logic [3:0]  out_bits_q;
  logic [2:0]  out_err_q;
  logic [31:0] sym_err_q, sym_err_d;
  logic [31:0] bit_err_q, bit_err_d;

  function automatic logic [1:0] gray(input logic [1:0] lvl);
    case (lvl)
      2'd0:    gray = 2'b11;
      2'd1:    gray = 2'b10;
      2'd2:    gray = 2'b00;
      default: gray = 2'b01;
    endcase
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    sat_add = s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Single shared comparator: cell and reference both selected by FSM position.
  logic [15:0] vth_cur, vref_cur;
  logic        below, cell_done;
  logic [1:0]  lvl_cur;
  logic [3:0]  bits_new, diff;
  logic [2:0]  err_bits_new;
  logic [1:0]  sym_new;
  logic        update;

  always_comb begin
    vth_cur = (state_q == SENSE_A) ? vth_a_q : vth_b_q;
    case (idx_q)
      2'd0:    vref_cur = VREF0;
      2'd1:    vref_cur = VREF1;
      default: vref_cur = VREF2;
    endcase
    below     = vth_cur < vref_cur;
    cell_done = below || (idx_q == 2'd2);
    lvl_cur   = below ? idx_q : 2'd3;
    bits_new  = {gray(lvl_a_q), gray(lvl_cur)};
    diff      = bits_new ^ exp_q;
    err_bits_new = '0;
    for (int i = 0; i < 4; i++) err_bits_new = err_bits_new + {2'b00, diff[i]};
    sym_new   = {1'b0, |diff[3:2]} + {1'b0, |diff[1:0]};
    update    = (state_q == SENSE_B) && cell_done;
  end

  // A coincident clear discards the word's errors.
  always_comb begin
    sym_err_d = sym_err_q;
    bit_err_d = bit_err_q;
    if (clr_cnt) begin
      sym_err_d = '0;
      bit_err_d = '0;
    end else if (update) begin
      sym_err_d = sat_add(sym_err_q, {30'd0, sym_new});
      bit_err_d = sat_add(bit_err_q, {29'd0, err_bits_new});
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym_err_q <= '0;
      bit_err_q <= '0;
    end else begin
      sym_err_q <= sym_err_d;
      bit_err_q <= bit_err_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      vth_a_q     <= '0;
      vth_b_q     <= '0;
      exp_q       <= '0;
      lvl_a_q     <= '0;
      out_valid_q <= 1'b0;
      out_lvl_a_q <= '0;
      out_lvl_b_q <= '0;
      out_bits_q  <= '0;
      out_err_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          vth_a_q <= bus.in_data[31:16];
          vth_b_q <= bus.in_data[15:0];
          exp_q   <= bus.in_expected;
          idx_q   <= '0;
          state_q <= SENSE_A;
        end
        SENSE_A: if (cell_done) begin
          lvl_a_q <= lvl_cur;
          idx_q   <= '0;
          state_q <= SENSE_B;
        end else begin
          idx_q   <= idx_q + 2'd1;
        end
        SENSE_B: if (cell_done) begin
          out_lvl_a_q <= lvl_a_q;
          out_lvl_b_q <= lvl_cur;
          out_bits_q  <= bits_new;
          out_err_q   <= err_bits_new;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end else begin
          idx_q <= idx_q + 2'd1;
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.out_valid    = out_valid_q;
  assign bus.out_level_a  = out_lvl_a_q;
  assign bus.out_level_b  = out_lvl_b_q;
  assign bus.out_bits     = out_bits_q;
  assign bus.out_err_bits = out_err_q;
  assign sym_err_cnt      = sym_err_q;
  assign bit_err_cnt      = bit_err_q;

endmodule

// File: tb/tb_vth_read_detector.sv
// Directed + randomized bench for vth_read_detector against a threshold/Gray-table model.
module tb_vth_read_detector;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clr_cnt = 1'b0;
  logic [31:0] sym_err_cnt, bit_err_cnt;

  vth_read_detector_if bus();

  vth_read_detector dut (
    .clk(clk), .reset(reset), .bus(bus), .clr_cnt(clr_cnt),
    .sym_err_cnt(sym_err_cnt), .bit_err_cnt(bit_err_cnt)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint m_sym = 0;
  longint m_bit = 0;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int lvl_of(input logic [15:0] v);
    if (v < 16'h0400) return 0;
    if (v < 16'h0800) return 1;
    if (v < 16'h0C00) return 2;
    return 3;
  endfunction

  function automatic logic [1:0] gray_of(input int l);
    logic [1:0] tbl [4];
    tbl = '{2'b11, 2'b10, 2'b00, 2'b01};
    return tbl[l];
  endfunction

  function automatic longint sat32(input longint x);
    return (x > 64'h0000_0000_FFFF_FFFF) ? 64'h0000_0000_FFFF_FFFF : x;
  endfunction

  function automatic int min3(input int x);
    return (x < 3) ? x : 3;
  endfunction

  function automatic logic [15:0] pick_vth();
    logic [15:0] r;
    case ($urandom_range(0, 2))
      0: r = 16'h0400;
      1: r = 16'h0800;
      default: r = 16'h0C00;
    endcase
    case ($urandom_range(0, 3))
      0: return 16'($urandom);
      1: return r - 16'd1;
      2: return r;
      default: return r + 16'd1;
    endcase
  endfunction

  // Send one word, check latency/results, hold out_ready low for `hold` cycles.
  task automatic send(input logic [31:0] d, input logic [3:0] e, input int hold, input bit clr_hit);
    int la, lb, lat, n, eb, es;
    logic [3:0] bits, diff;
    la   = lvl_of(d[31:16]);
    lb   = lvl_of(d[15:0]);
    lat  = min3(la + 1) + min3(lb + 1) + 1;
    bits = {gray_of(la), gray_of(lb)};
    diff = bits ^ e;
    eb   = $countones(diff);
    es   = int'(diff[3:2] != 2'b00) + int'(diff[1:0] != 2'b00);

    n = 0;
    while (!bus.in_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_expected = e;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_data = $urandom; bus.in_expected = 4'($urandom);
    n = 1;
    while (!bus.out_valid && n < 12) begin
      if (clr_hit && n == lat - 1) clr_cnt = 1'b1;
      @(posedge clk); #1;
      clr_cnt = 1'b0;
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    if (clr_hit) begin
      m_sym = 0; m_bit = 0;
    end else begin
      m_sym = sat32(m_sym + es);
      m_bit = sat32(m_bit + eb);
    end
    chk("level_a", 32'(bus.out_level_a), 32'(la));
    chk("level_b", 32'(bus.out_level_b), 32'(lb));
    chk("out_bits", 32'(bus.out_bits), 32'(bits));
    chk("err_bits", 32'(bus.out_err_bits), 32'(eb));
    chk("sym_cnt", sym_err_cnt, 32'(m_sym));
    chk("bit_cnt", bit_err_cnt, 32'(m_bit));

    for (int i = 0; i < hold; i++) begin
      bus.in_valid = i[0];
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_bits", 32'(bus.out_bits), 32'(bits));
      chk("hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("release_valid", 32'(bus.out_valid), 32'd0);
    chk("release_ready", 32'(bus.in_ready), 32'd1);
    chk("post_sym_cnt", sym_err_cnt, 32'(m_sym));
    chk("post_bit_cnt", bit_err_cnt, 32'(m_bit));
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_expected = '0; bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_level_a", 32'(bus.out_level_a), 32'd0);
    chk("rst_level_b", 32'(bus.out_level_b), 32'd0);
    chk("rst_bits", 32'(bus.out_bits), 32'd0);
    chk("rst_err", 32'(bus.out_err_bits), 32'd0);
    chk("rst_sym", sym_err_cnt, 32'd0);
    chk("rst_bit", bit_err_cnt, 32'd0);
    @(negedge clk); reset = 1'b1;

    // Directed: level 0 pair, tie + top level, counted errors
    send(32'h0100_0200, 4'b1111, 0, 1'b0);
    send(32'h0800_0FFF, 4'b0001, 0, 1'b0);
    send(32'h0C00_0000, 4'b0011, 0, 1'b0);
    chk("err_word_sym", sym_err_cnt, 32'd1);
    chk("err_word_bit", bit_err_cnt, 32'd1);

    // Backpressure with in_valid pulsing
    send(32'h0500_0900, 4'b0000, 5, 1'b0);

    // Reset during SENSE_B of a level-2/level-2 word
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 32'h0900_0A00; bus.in_expected = 4'b1111;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_sym", sym_err_cnt, 32'd0);
    chk("midrst_bit", bit_err_cnt, 32'd0);
    @(posedge clk); #1;
    chk("midrst_hold_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk); reset = 1'b1;
    m_sym = 0; m_bit = 0;
    send(32'h0700_0C01, 4'b1000, 0, 1'b0);

    // Saturation of bit counter
    @(negedge clk);
    force dut.bit_err_q = 32'hFFFF_FFFE;
    #1;
    release dut.bit_err_q;
    m_bit = 64'h0000_0000_FFFF_FFFE;
    send(32'h0100_0200, 4'b0000, 0, 1'b0);
    chk("sat_bit", bit_err_cnt, 32'hFFFF_FFFF);
    send(32'h0100_0200, 4'b0000, 1, 1'b0);

    // Clear coincident with update wins
    send(32'h0100_0200, 4'b0000, 0, 1'b1);
    chk("clr_sym", sym_err_cnt, 32'd0);
    chk("clr_bit", bit_err_cnt, 32'd0);

    // Randomized words
    for (int k = 0; k < 24; k++) begin
      logic [31:0] d;
      logic [3:0]  e;
      d = {pick_vth(), pick_vth()};
      if ($urandom_range(0, 1) == 0)
        e = {gray_of(lvl_of(d[31:16])), gray_of(lvl_of(d[15:0]))};
      else
        e = 4'($urandom);
      send(d, e, $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
